// File: rtl/tx_fire_pulse_generator_if.sv
// Fire-request / status bundle between the transmit output controller (master)
// and tx_fire_pulse_generator (slave). TX_DANGER_KILL_EN adds the kill line.
interface tx_fire_pulse_generator_if #(
  parameter int NUM_CH   = 8,
  parameter int DELAY_W  = 16,
  parameter int CHARGE_W = 9
);

  logic                       itxFire;
  logic [NUM_CH*DELAY_W-1:0]  itxPhaseDelays;
  logic [CHARGE_W-1:0]        itxChargeTime;
  logic [NUM_CH-1:0]          itxChannelMask;
  logic                       itxAbort;
`ifdef TX_DANGER_KILL_EN
  logic                       itxToAll_Danger_KillProgram;
`endif
  logic [NUM_CH-1:0]          otxTransducerOutput;
  logic                       otxBusy;
  logic                       otxDone;
  logic                       otxFireError;

`ifdef TX_DANGER_KILL_EN
  modport master (
    output itxFire, itxPhaseDelays, itxChargeTime, itxChannelMask, itxAbort,
           itxToAll_Danger_KillProgram,
    input  otxTransducerOutput, otxBusy, otxDone, otxFireError
  );

  modport slave (
    input  itxFire, itxPhaseDelays, itxChargeTime, itxChannelMask, itxAbort,
           itxToAll_Danger_KillProgram,
    output otxTransducerOutput, otxBusy, otxDone, otxFireError
  );
`else
  modport master (
    output itxFire, itxPhaseDelays, itxChargeTime, itxChannelMask, itxAbort,
    input  otxTransducerOutput, otxBusy, otxDone, otxFireError
  );

  modport slave (
    input  itxFire, itxPhaseDelays, itxChargeTime, itxChannelMask, itxAbort,
    output otxTransducerOutput, otxBusy, otxDone, otxFireError
  );
`endif

endinterface

// File: rtl/tx_fire_pulse_generator.sv
// Per-channel delayed transducer pulse generator, started by a one-cycle fire strobe.
// Optional macro TX_DANGER_KILL_EN adds a combinational kill input that forces all lines low.
module tx_fire_pulse_generator #(
  parameter int NUM_CH   = 8,
  parameter int DELAY_W  = 16,
  parameter int CHARGE_W = 9
) (
  input  logic                       txCLK,
  input  logic                       txRESETn,
  tx_fire_pulse_generator_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRING = 2'd1,
    DONE   = 2'd2
  } txState_t;

  typedef logic [DELAY_W:0]    tick_t;
  typedef logic [DELAY_W-1:0]  delay_t;
  typedef logic [CHARGE_W-1:0] charge_t;

  // The tick counter is one bit wider than a delay, so the longest pulse only
  // fits if the charge field is no wider than the delay field.
  if (CHARGE_W > DELAY_W) begin : gBadWidths
    $error("tx_fire_pulse_generator: CHARGE_W must not exceed DELAY_W");
  end
  if (NUM_CH < 1) begin : gBadChannels
    $error("tx_fire_pulse_generator: NUM_CH must be at least 1");
  end

  txState_t          state, stateNext;
  tick_t             t, tNext;
  delay_t            delayReg [NUM_CH];
  charge_t           chargeReg;
  logic [NUM_CH-1:0] maskReg;
  logic [NUM_CH-1:0] driveReg, driveNext;
  logic              doneReg, doneNext;
  logic              errReg, errNext;
  logic              load;

  delay_t            delayIn [NUM_CH];
  tick_t             endTime [NUM_CH];
  tick_t             tEnd;
  logic [NUM_CH-1:0] hit;
  logic              busy;
  logic              kill;

`ifdef TX_DANGER_KILL_EN
  logic killPrev;

  assign kill = bus.itxToAll_Danger_KillProgram;

  always_ff @(posedge txCLK or negedge txRESETn) begin
    if (!txRESETn) killPrev <= 1'b0;
    else           killPrev <= kill;
  end
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      delayIn[i] = bus.itxPhaseDelays[i*DELAY_W +: DELAY_W];
    end
  end

  // Window and completion time come from the latched fire parameters only.
  always_comb begin
    tEnd = '0;
    hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      endTime[i] = tick_t'(delayReg[i]) + tick_t'(chargeReg);
      hit[i]     = maskReg[i] && (chargeReg != '0) &&
                   (t >= tick_t'(delayReg[i])) && (t < endTime[i]);
      if (maskReg[i] && (chargeReg != '0) && (endTime[i] > tEnd)) begin
        tEnd = endTime[i];
      end
    end
  end

  // Busy also covers the done-pulse cycle, when the FSM is already back in IDLE.
  assign busy = (state != IDLE) || doneReg;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    stateNext = state;
    tNext     = t;
    driveNext = '0;
    doneNext  = 1'b0;
    errNext   = bus.itxFire && busy;
    load      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.itxFire && !doneReg) begin
          load      = 1'b1;
          tNext     = '0;
          stateNext = FIRING;
        end
      end
      FIRING: begin
        if (bus.itxAbort) begin
          stateNext = IDLE;
        end else if (t == tEnd) begin
          stateNext = DONE;
        end else begin
          driveNext = hit;
          tNext     = t + tick_t'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
        doneNext  = !bus.itxAbort;
      end
      default: stateNext = IDLE;
    endcase

`ifdef TX_DANGER_KILL_EN
    if (kill) begin
      stateNext = IDLE;
      driveNext = '0;
      doneNext  = 1'b0;
      load      = 1'b0;
      errNext   = !killPrev;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge txCLK or negedge txRESETn) begin
    if (!txRESETn) begin
      state    <= IDLE;
      t        <= '0;
      driveReg <= '0;
      doneReg  <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      state    <= stateNext;
      t        <= tNext;
      driveReg <= driveNext;
      doneReg  <= doneNext;
      errReg   <= errNext;
    end
  end

  // NOTE: the latched fire parameters are a small register bank, not a RAM,
  // so they take the async reset and come up as all-zero.
  always_ff @(posedge txCLK or negedge txRESETn) begin
    if (!txRESETn) begin
      for (int i = 0; i < NUM_CH; i++) delayReg[i] <= '0;
      chargeReg <= '0;
      maskReg   <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_CH; i++) delayReg[i] <= delayIn[i];
      chargeReg <= bus.itxChargeTime;
      maskReg   <= bus.itxChannelMask;
    end
  end

  assign bus.otxTransducerOutput = driveReg & ~{NUM_CH{kill}};
  assign bus.otxBusy             = busy;
  assign bus.otxDone             = doneReg;
  assign bus.otxFireError        = errReg;

  aDoneSingle : assert property (@(posedge txCLK) disable iff (!txRESETn)
    doneReg |=> !doneReg);

  aDriveOnlyFiring : assert property (@(posedge txCLK) disable iff (!txRESETn)
    (driveReg != '0) |-> (state == FIRING));

endmodule
